// File: rtl/tetris_host_pkg.sv
// Shared types and widths for the TETRIS host sequencer.
//   host_state_t : sequencer states
//   piece_t      : one buffered piece command (tetromino, column)
package tetris_host_pkg;

  localparam int unsigned TET_W   = 3;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ROWS    = 12;
  localparam int unsigned COLS    = 6;
  localparam int unsigned BOARD_W = ROWS * COLS;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    FLUSH
  } host_state_t;

  typedef struct packed {
    logic [TET_W-1:0] tetromino;
    logic [POS_W-1:0] position;
  } piece_t;

endpackage

// File: rtl/tetris_host_if.sv
// Bus bundle between the host sequencer and its environment.
//   cmd_*   : upstream piece commands (valid/ready)
//   in_valid, tetrominoes, position : piece strobe towards the core
//   score_valid, fail, score, tetris_valid, tetris : core responses
//   res_*   : round result record (valid/ready)
//   proto_err : sticky protocol error
// master = host side, slave = environment side.
interface tetris_host_if;
  import tetris_host_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [TET_W-1:0]   cmd_tetromino;
  logic [POS_W-1:0]   cmd_position;

  logic               in_valid;
  logic [TET_W-1:0]   tetrominoes;
  logic [POS_W-1:0]   position;

  logic               score_valid;
  logic               fail;
  logic [SCORE_W-1:0] score;
  logic               tetris_valid;
  logic [BOARD_W-1:0] tetris;

  logic               res_valid;
  logic               res_ready;
  logic [SCORE_W-1:0] res_score;
  logic               res_fail;
  logic               res_timeout;
  logic [4:0]         res_pieces;
  logic [BOARD_W-1:0] res_board;
  logic               proto_err;

  modport master (
    input  cmd_valid, cmd_tetromino, cmd_position,
    input  score_valid, fail, score, tetris_valid, tetris,
    input  res_ready,
    output cmd_ready, in_valid, tetrominoes, position,
    output res_valid, res_score, res_fail, res_timeout, res_pieces, res_board,
    output proto_err
  );

  modport slave (
    output cmd_valid, cmd_tetromino, cmd_position,
    output score_valid, fail, score, tetris_valid, tetris,
    output res_ready,
    input  cmd_ready, in_valid, tetrominoes, position,
    input  res_valid, res_score, res_fail, res_timeout, res_pieces, res_board,
    input  proto_err
  );

endinterface

// File: rtl/tetris_cmd_fifo.sv
// Synchronous command FIFO of piece_t, no bypass.
//   clk, rst       : clock, synchronous active-high reset
//   push, wdata    : write (ignored when full)
//   pop            : read advance (ignored when empty)
//   rdata_c        : head entry
//   full_c, empty_c: occupancy flags
module tetris_cmd_fifo
  import tetris_host_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  piece_t wdata,
  input  logic   pop,
  output piece_t rdata_c,
  output logic   full_c,
  output logic   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  piece_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra MSB tells a wrapped (full) pointer pair from an equal (empty) one.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full_c) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty_c) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tetris_host.sv
// Host-side sequencer for the TETRIS core: buffers piece commands, issues
// them one at a time, waits (bounded) for each score, and packages each
// round as one result record.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tetris_host_if.master (command, core and result channels)
module tetris_host
  import tetris_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned PIECES_PER_ROUND = 16,
  parameter int unsigned TIMEOUT          = 1023
) (
  input  logic          clk,
  input  logic          rst,
  tetris_host_if.master bus
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  PPR       = CNT_W'(PIECES_PER_ROUND);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  host_state_t        state, state_next;
  logic               in_valid, in_valid_next;
  logic [TET_W-1:0]   tet, tet_next;
  logic [POS_W-1:0]   pos, pos_next;
  logic [CNT_W-1:0]   piece_cnt, piece_cnt_next;
  logic [CNT_W-1:0]   flush_cnt, flush_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_next;
  logic               res_valid, res_valid_next;
  logic [SCORE_W-1:0] res_score, res_score_next;
  logic               res_fail, res_fail_next;
  logic               res_timeout, res_timeout_next;
  logic [BOARD_W-1:0] res_board, res_board_next;
  logic               proto_err, proto_err_next;

  logic   pop_c;
  logic   full_c;
  logic   empty_c;
  piece_t head_c;
  piece_t cmd_c;

  assign cmd_c = '{tetromino: bus.cmd_tetromino, position: bus.cmd_position};

  tetris_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cmd_valid),
    .wdata   (cmd_c),
    .pop     (pop_c),
    .rdata_c (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_valid    <= 1'b0;
      tet         <= '0;
      pos         <= '0;
      piece_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      res_valid   <= 1'b0;
      res_score   <= '0;
      res_fail    <= 1'b0;
      res_timeout <= 1'b0;
      res_board   <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_next;
      in_valid    <= in_valid_next;
      tet         <= tet_next;
      pos         <= pos_next;
      piece_cnt   <= piece_cnt_next;
      flush_cnt   <= flush_cnt_next;
      wait_cnt    <= wait_cnt_next;
      res_valid   <= res_valid_next;
      res_score   <= res_score_next;
      res_fail    <= res_fail_next;
      res_timeout <= res_timeout_next;
      res_board   <= res_board_next;
      proto_err   <= proto_err_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next       = state;
    in_valid_next    = 1'b0;
    tet_next         = '0;
    pos_next         = '0;
    piece_cnt_next   = piece_cnt;
    flush_cnt_next   = flush_cnt;
    wait_cnt_next    = wait_cnt;
    res_valid_next   = res_valid;
    res_score_next   = res_score;
    res_fail_next    = res_fail;
    res_timeout_next = res_timeout;
    res_board_next   = res_board;
    proto_err_next   = proto_err;
    pop_c            = 1'b0;

    // Core strobes are only meaningful while a piece is outstanding.
    if ((bus.score_valid || bus.tetris_valid) && (state != WAIT)) begin
      proto_err_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!empty_c) begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        in_valid_next = 1'b1;
        tet_next      = head_c.tetromino;
        pos_next      = head_c.position;
        pop_c         = 1'b1;
        if (piece_cnt != PPR) begin
          piece_cnt_next = piece_cnt + CNT_W'(1);
        end
        wait_cnt_next = '0;
        state_next    = WAIT;
      end

      WAIT: begin
        wait_cnt_next = wait_cnt + WAIT_W'(1);
        if (bus.score_valid) begin
          res_score_next = bus.score;
          res_fail_next  = bus.fail;
          if (bus.tetris_valid) begin
            res_board_next = bus.tetris;
          end
          // A round-ending response must carry the final board.
          if ((bus.fail || (piece_cnt == PPR)) && !bus.tetris_valid) begin
            proto_err_next = 1'b1;
          end
          if (bus.fail) begin
            state_next     = DONE;
            res_valid_next = 1'b1;
            flush_cnt_next = PPR - piece_cnt;
          end else if (piece_cnt == PPR) begin
            state_next     = DONE;
            res_valid_next = 1'b1;
            flush_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_next       = DONE;
          res_valid_next   = 1'b1;
          res_timeout_next = 1'b1;
          res_board_next   = '0;
          flush_cnt_next   = PPR - piece_cnt;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          res_valid_next   = 1'b0;
          piece_cnt_next   = '0;
          res_fail_next    = 1'b0;
          res_timeout_next = 1'b0;
          state_next       = (flush_cnt != '0) ? FLUSH : IDLE;
        end
      end

      FLUSH: begin
        // Discard the unissued remainder of an aborted round.
        if (flush_cnt == '0) begin
          state_next = IDLE;
        end else if (!empty_c) begin
          pop_c          = 1'b1;
          flush_cnt_next = flush_cnt - CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = !full_c;
  assign bus.in_valid    = in_valid;
  assign bus.tetrominoes = tet;
  assign bus.position    = pos;
  assign bus.res_valid   = res_valid;
  assign bus.res_score   = res_score;
  assign bus.res_fail    = res_fail;
  assign bus.res_timeout = res_timeout;
  assign bus.res_pieces  = piece_cnt;
  assign bus.res_board   = res_board;
  assign bus.proto_err   = proto_err;

endmodule

// File: doc/tetris_host.md
Name: tetris_host

Overview:
- Host-side sequencer that drives the TETRIS core's piece interface (in_valid / tetrominoes / position) and consumes its result interface (score_valid / fail / score / tetris_valid / tetris).
- Buffers upstream piece commands and issues them one at a time, waiting for each score response.
- Bounds each wait with a timeout.
- Packages each finished round (16 pieces, or early fail) as one result record behind a valid/ready handshake.
- Sits on the test/host side of the chip boundary, opposite the TETRIS core.

Parameters:
- FIFO_DEPTH, 4: command buffer entries; power of two, at least 2.
- PIECES_PER_ROUND, 16: pieces per round.
- TIMEOUT, 1023: maximum cycles spent in WAIT before the round is aborted.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  upstream piece command valid.
- cmd_ready  out  1  equals !fifo_full.
- cmd_tetromino  in  3  piece type.
- cmd_position  in  3  column 0-5.
- in_valid  out  1  one-cycle piece strobe to the core.
- tetrominoes  out  3  piece type to the core; 0 when in_valid=0.
- position  out  3  column to the core; 0 when in_valid=0.
- score_valid  in  1  core per-piece response strobe.
- fail  in  1  core fail flag, qualified by score_valid.
- score  in  4  core running score, qualified by score_valid.
- tetris_valid  in  1  core board strobe; asserted only together with score_valid.
- tetris  in  72  core board, 12 rows x 6 columns, bit 0 = row 0 column 0.
- res_valid  out  1  round result valid.
- res_ready  in  1  result accepted.
- res_score  out  4  final score.
- res_fail  out  1  round ended by fail.
- res_timeout  out  1  round ended by timeout.
- res_pieces  out  5  pieces issued in the round, 1-16.
- res_board  out  72  latched board; 0 on timeout.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset and clock:
  - One clock. Reset is synchronous and active-high: while rst=1 at a rising edge, all state clears.
  - Reset values: in_valid, tetrominoes, position, res_* and proto_err are 0; FIFO is empty; state is IDLE; counters are 0.
  - cmd_ready is 1 from the first cycle after reset.
  - Reset mid-round discards all buffered and in-flight state; no partial result is produced.
- FIFO:
  - A push happens when cmd_valid && cmd_ready.
  - When full, cmd_ready=0. There is no bypass: a push into an empty FIFO is poppable on the next cycle.
  - Push and pop in the same cycle are both honoured.
  - Read/write pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- States: IDLE, ISSUE, WAIT, DONE, FLUSH.
- IDLE:
  - FIFO non-empty -> ISSUE.
- ISSUE (exactly one cycle):
  - Registered in_valid=1 with the head entry; pop; piece_cnt++.
  - Go to WAIT; clear wait_cnt.
  - in_valid is never asserted on two consecutive cycles.
- WAIT:
  - wait_cnt++ each cycle.
  - On score_valid: latch score into res_score and fail into res_fail.
  - If tetris_valid is also high, latch tetris into res_board.
  - Next state on score_valid:
    - fail=1 -> DONE, with flush_cnt = PIECES_PER_ROUND - piece_cnt.
    - Otherwise piece_cnt==PIECES_PER_ROUND -> DONE.
    - Otherwise -> IDLE.
  - If fail=1, or piece_cnt==PIECES_PER_ROUND, and tetris_valid=0 on that same cycle: set proto_err and keep the previous res_board.
  - If wait_cnt reaches TIMEOUT with no score_valid: DONE with res_timeout=1, res_board=0, flush_cnt = PIECES_PER_ROUND - piece_cnt.
- DONE:
  - res_valid=1; all res_* are held stable until res_ready.
  - On handshake: res_valid=0 on the next cycle; clear piece_cnt, res_fail and res_timeout.
  - flush_cnt>0 -> FLUSH; otherwise -> IDLE.
- FLUSH:
  - Pop one FIFO entry per cycle when non-empty, without driving in_valid; flush_cnt--.
  - flush_cnt==0 -> IDLE. An empty FIFO stalls in FLUSH.
- Protocol errors:
  - score_valid or tetris_valid outside WAIT sets proto_err and is otherwise ignored.
  - proto_err clears only on rst.
- Widths:
  - piece_cnt is 5 bits and saturates at 16.
  - wait_cnt is $clog2(TIMEOUT+1) bits.

Decomposition:
- Package tetris_host_pkg holds:
  - state enum host_state_t;
  - widths TET_W=3, POS_W=3, SCORE_W=4, BOARD_W=72;
  - constants ROWS=12, COLS=6;
  - type piece_t = struct {tetromino, position}.
- One sub-module, tetris_cmd_fifo: parameterised synchronous FIFO of piece_t with full/empty flags. The FSM and counters stay in tetris_host.

Test Plan:
1. Push 16 commands, core model replies score_valid 2 cycles after each in_valid with score=piece index mod 16 and fail=0, tetris_valid on the 16th -> 16 in_valid pulses, never back-to-back; one result with res_pieces=16, res_fail=0, res_score=15, res_board equal to the model board.
2. Core asserts fail=1 with tetris_valid on piece 5; upstream pushes 16 commands -> result res_pieces=5, res_fail=1; the next 11 commands are popped without in_valid; command 17 issues as piece 1 of the next round.
3. Core never responds after piece 3 -> after TIMEOUT cycles, res_timeout=1, res_board=0, res_pieces=3; 13 commands are flushed.
4. res_ready held 0 for 20 cycles while 8 commands are pushed -> res_* stable; cmd_ready drops to 0 after 4 buffered; no in_valid until the handshake.
5. rst pulsed during WAIT of piece 7 -> next cycle in_valid=0, res_valid=0, FIFO empty, cmd_ready=1; a new round starts at piece 1.
6. score_valid injected in IDLE -> proto_err=1 and held until rst; the round otherwise completes normally.
